seq_detector: RTL and testbench

Mealy finite-state machine that watches a serial bit stream for the pattern 01[0*]1, where [0*] is zero or more zeros. It flags each match combinationally and counts matches in a two-digit BCD counter. The counter drives two 7-segment digit outputs. It is the top-level datapath of the sequence-detection project, fed by a one-bit test input and driving a two-digit display.

---
 rtl/seq_detector_pkg.sv | 19 +
 rtl/seq_detector_seg7_decoder.sv | 17 +
 rtl/seq_detector.sv | 66 ++++++
 tb/tb_seq_detector.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_pkg.sv
// Shared types and constants for the seq_detector block: FSM state encoding,
// BCD digit width and the 7-segment (gfedcba, active-high) glyph table.
package seq_detector_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT0   = 2'd1,
        GOT01  = 2'd2,
        GOT010 = 2'd3
    } state_t;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage

// File: rtl/seq_detector_seg7_decoder.sv
// Combinational BCD to 7-segment decoder; digit values above 9 show blank.
module seg7_decoder
    import seq_detector_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        seg = 7'h00;
        if (bcd < BCD_W'(10)) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Mealy detector for the serial pattern 01[0*]1 with a two-digit BCD match
// counter shown on two 7-segment digits. Define SEQDET_BLANK_LEADING_ZERO_EN
// to blank the tens digit while it is zero.
module seq_detector
    import seq_detector_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       sig_to_test,
    output logic [6:0] disp0,
    output logic [6:0] disp1,
    output logic       z
);

    state_t           state;
    logic [BCD_W-1:0] ones;
    logic [BCD_W-1:0] tens;
    logic [6:0]       tens_seg;

    // Gating with rst keeps the flag low while reset is asserted, even before the first edge.
    assign z = rst & ena & sig_to_test & ((state == GOT01) | (state == GOT010));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ones  <= '0;
            tens  <= '0;
        end else if (ena) begin
            case (state)
                IDLE:   state <= sig_to_test ? IDLE  : GOT0;
                GOT0:   state <= sig_to_test ? GOT01 : GOT0;
                GOT01:  state <= sig_to_test ? IDLE  : GOT010;
                GOT010: state <= sig_to_test ? IDLE  : GOT010;
                default: state <= IDLE;
            endcase

            if (z) begin
                if (ones == BCD_W'(9)) begin
                    ones <= '0;
                    tens <= (tens == BCD_W'(9)) ? '0 : tens + BCD_W'(1);
                end else begin
                    ones <= ones + BCD_W'(1);
                end
            end
        end
    end

    seg7_decoder u_dec_ones (
        .bcd (ones),
        .seg (disp0)
    );

    seg7_decoder u_dec_tens (
        .bcd (tens),
        .seg (tens_seg)
    );

`ifdef SEQDET_BLANK_LEADING_ZERO_EN
    assign disp1 = (tens == '0) ? 7'h00 : tens_seg;
`else
    assign disp1 = tens_seg;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: reference-stream table, directed corner
// sequences and randomized traffic against a pattern-level reference model.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       sig_to_test;
    logic [6:0] disp0;
    logic [6:0] disp1;
    logic       z;

    int vectors    = 0;
    int miscompares = 0;

    logic [6:0] seg_ref [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Reference model: bits accepted since the last match or reset, and match count.
    logic q[$];
    int   model_count = 0;
    logic last_z;

    seq_detector dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .sig_to_test (sig_to_test),
        .disp0       (disp0),
        .disp1       (disp1),
        .z           (z)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // A match is a suffix 0 1 0* 1 of the bits seen since the last match.
    function automatic logic suffix_matches();
        int n = q.size();
        int i;
        if (n < 3 || q[n-1] != 1'b1) return 1'b0;
        i = n - 2;
        while (i >= 0 && q[i] == 1'b0) i--;
        return (i >= 1) && (q[i] == 1'b1) && (q[i-1] == 1'b0);
    endfunction

    task automatic model_step(input logic r, input logic e, input logic b, output logic mz);
        mz = 1'b0;
        if (!r) begin
            q.delete();
            model_count = 0;
        end else if (e) begin
            q.push_back(b);
            if (suffix_matches()) begin
                mz = 1'b1;
                model_count = (model_count + 1) % 100;
                q.delete();
            end
        end
    endtask

    task automatic check_disp(input string tag);
        logic [6:0] exp1;
        int tens = model_count / 10;
        exp1 = seg_ref[tens];
`ifdef SEQDET_BLANK_LEADING_ZERO_EN
        if (tens == 0) exp1 = 7'h00;
`endif
        check({tag, "_disp0"}, {1'b0, disp0}, {1'b0, seg_ref[model_count % 10]});
        check({tag, "_disp1"}, {1'b0, disp1}, {1'b0, exp1});
    endtask

    // One clock: drive at negedge, check z mid-cycle, check displays after the edge.
    task automatic cyc(input logic r, input logic e, input logic b, input string tag);
        logic mz;
        model_step(r, e, b, mz);
        @(negedge clk);
        rst = r;
        ena = e;
        sig_to_test = b;
        #1;
        last_z = z;
        check({tag, "_z"}, {7'b0, z}, {7'b0, mz});
        @(posedge clk);
        #1;
        check_disp(tag);
    endtask

    typedef struct {
        logic sig;
        logic exp_z;
        int   exp_count;
    } vec_t;

    vec_t  tbl[24];
    string ref_bits;
    int    hits[4] = '{6, 13, 19, 23};

    initial begin
        int cnt;
        rst = 1'b0;
        ena = 1'b1;
        sig_to_test = 1'b0;

        ref_bits = "000100110001011101010011";
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            tbl[i].sig   = (ref_bits[i] == "1");
            tbl[i].exp_z = 1'b0;
            foreach (hits[k]) if (hits[k] == i) tbl[i].exp_z = 1'b1;
            if (tbl[i].exp_z) cnt++;
            tbl[i].exp_count = cnt;
        end

        // Reset held two cycles with the input toggling.
        cyc(1'b0, 1'b1, 1'b0, "rst0");
        cyc(1'b0, 1'b1, 1'b1, "rst1");

        // Reference stream from the table.
        for (int i = 0; i < 24; i++) begin
            cyc(1'b1, 1'b1, tbl[i].sig, "ref");
            check("ref_tbl_z", {7'b0, last_z}, {7'b0, tbl[i].exp_z});
            check("ref_tbl_cnt", {1'b0, disp0}, {1'b0, seg_ref[tbl[i].exp_count % 10]});
        end

        // Minimal match then a lone 1 that must not match.
        cyc(1'b0, 1'b1, 1'b0, "min_rst");
        cyc(1'b1, 1'b1, 1'b0, "min");
        cyc(1'b1, 1'b1, 1'b1, "min");
        cyc(1'b1, 1'b1, 1'b1, "min");
        check("min_match_z", {7'b0, last_z}, 8'd1);
        cyc(1'b1, 1'b1, 1'b1, "min_again");
        check("min_nomatch_z", {7'b0, last_z}, 8'd0);
        check("min_count", {1'b0, disp0}, {1'b0, seg_ref[1]});

        // Enable gating: the held cycle drops its bit and keeps GOT01.
        cyc(1'b1, 1'b1, 1'b0, "ena");
        cyc(1'b1, 1'b1, 1'b1, "ena");
        cyc(1'b1, 1'b0, 1'b1, "ena_off");
        check("ena_off_z", {7'b0, last_z}, 8'd0);
        check("ena_off_count", {1'b0, disp0}, {1'b0, seg_ref[1]});
        cyc(1'b1, 1'b1, 1'b1, "ena_on");
        check("ena_on_z", {7'b0, last_z}, 8'd1);
        check("ena_on_count", {1'b0, disp0}, {1'b0, seg_ref[2]});

        // Wrap: 100 back-to-back 011 matches from zero.
        cyc(1'b0, 1'b1, 1'b0, "wrap_rst");
        for (int m = 1; m <= 100; m++) begin
            cyc(1'b1, 1'b1, 1'b0, "wrap");
            cyc(1'b1, 1'b1, 1'b1, "wrap");
            cyc(1'b1, 1'b1, 1'b1, "wrap");
            if (m == 99) begin
                check("wrap99_disp0", {1'b0, disp0}, {1'b0, seg_ref[9]});
                check("wrap99_disp1", {1'b0, disp1}, {1'b0, seg_ref[9]});
            end
        end
        check("wrap100_disp0", {1'b0, disp0}, 8'h3F);
`ifdef SEQDET_BLANK_LEADING_ZERO_EN
        check("wrap100_disp1", {1'b0, disp1}, 8'h00);
`else
        check("wrap100_disp1", {1'b0, disp1}, 8'h3F);
`endif

        // Mid-sequence reset discards progress.
        cyc(1'b0, 1'b1, 1'b0, "mid_rst");
        cyc(1'b1, 1'b1, 1'b0, "mid");
        cyc(1'b1, 1'b1, 1'b1, "mid");
        cyc(1'b1, 1'b1, 1'b0, "mid");
        cyc(1'b1, 1'b1, 1'b0, "mid");
        cyc(1'b0, 1'b1, 1'b1, "mid_rst");
        cyc(1'b1, 1'b1, 1'b1, "mid_after");
        check("mid_after_z", {7'b0, last_z}, 8'd0);
        check("mid_after_count", {1'b0, disp0}, 8'h3F);

        // Randomized traffic with sparse resets and enable drops.
        for (int i = 0; i < 3000; i++) begin
            logic r, e, b;
            r = ($urandom_range(0, 99) != 0);
            e = ($urandom_range(0, 9) != 0);
            b = $urandom_range(0, 1);
            cyc(r, e, b, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
